// File: rtl/padmux_if.sv
// Pad-mux controller bundle: pad-config, peripheral-function and pad-ring signals.
// The controller uses the slave modport; the config/peripheral/pad side uses master.
interface padmux_if #(
  parameter int NUM_PADS = 8,
  parameter int NUM_FUNC = 4,
  parameter int SEL_W    = 3,
  parameter int DEB_W    = 8
);
  logic [NUM_PADS*SEL_W-1:0]    cfg_sel_i;
  logic [NUM_PADS-1:0]          cfg_deb_en_i;
  logic [DEB_W-1:0]             cfg_deb_thr_i;
  logic [NUM_PADS*NUM_FUNC-1:0] func_out_i;
  logic [NUM_PADS*NUM_FUNC-1:0] func_oe_i;
  logic [NUM_PADS*NUM_FUNC-1:0] func_in_o;
  logic [NUM_PADS-1:0]          pad_in_i;
  logic [NUM_PADS-1:0]          pad_out_o;
  logic [NUM_PADS-1:0]          pad_oe_o;
  logic [NUM_PADS-1:0]          switch_busy_o;
  logic [NUM_PADS-1:0]          switch_done_o;
  // Per-pad FSM state for checkers: 0 = ACTIVE, 1 = GUARD.
  logic [NUM_PADS-1:0]          state_dbg;

  modport master (
    output cfg_sel_i, cfg_deb_en_i, cfg_deb_thr_i, func_out_i, func_oe_i, pad_in_i,
    input  func_in_o, pad_out_o, pad_oe_o, switch_busy_o, switch_done_o, state_dbg
  );

  modport slave (
    input  cfg_sel_i, cfg_deb_en_i, cfg_deb_thr_i, func_out_i, func_oe_i, pad_in_i,
    output func_in_o, pad_out_o, pad_oe_o, switch_busy_o, switch_done_o, state_dbg
  );
endinterface

// File: rtl/padmux_ctrl.sv
// Per-pad function multiplexer with break-before-make guard interval,
// 2-flop input synchroniser and optional per-pad debounce filter.
module padmux_ctrl #(
  parameter int NUM_PADS     = 8,
  parameter int NUM_FUNC     = 4,
  parameter int SEL_W        = 3,
  parameter int GUARD_CYCLES = 4,
  parameter int DEB_W        = 8
) (
  input logic     clk,
  input logic     rst,
  padmux_if.slave bus
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GUARD  = 1'b1
  } pad_state_e;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_state_e          state_q, state_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    cfg_sel;
    logic                out_q, out_d;
    logic                oe_q, oe_d;
    logic                done_q, done_d;
    logic                drv_out, drv_oe;
    logic                sync1_q, sync2_q;
    logic                filt_q, filt_d;
    logic [DEB_W-1:0]    dcnt_q, dcnt_d;
    logic [NUM_FUNC-1:0] fin;

    assign cfg_sel = bus.cfg_sel_i[p*SEL_W +: SEL_W];

    // Park codes (sel >= NUM_FUNC) match no function and so drive nothing.
    always_comb begin
      drv_out = 1'b0;
      drv_oe  = 1'b0;
      for (int f = 0; f < NUM_FUNC; f++) begin
        if (sel_q == SEL_W'(f)) begin
          drv_out = bus.func_out_i[p*NUM_FUNC + f];
          drv_oe  = bus.func_oe_i[p*NUM_FUNC + f];
        end
      end
    end

    always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      sel_d   = sel_q;
      out_d   = 1'b0;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        ST_ACTIVE: begin
          if (cfg_sel != sel_q) begin
            state_d = ST_GUARD;
            gcnt_d  = GUARD_LOAD;
          end else begin
            out_d = drv_out;
            oe_d  = drv_oe;
          end
        end
        ST_GUARD: begin
          // Whatever cfg_sel holds at the exit edge wins; changes mid-guard never restart the count.
          if (gcnt_q == '0) begin
            state_d = ST_ACTIVE;
            sel_d   = cfg_sel;
            done_d  = 1'b1;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
      endcase
    end

    // Threshold is compared with >= so a lowered threshold takes effect at once.
    always_comb begin
      filt_d = filt_q;
      dcnt_d = dcnt_q;
      if (!bus.cfg_deb_en_i[p] || bus.cfg_deb_thr_i == '0) begin
        filt_d = sync2_q;
        dcnt_d = '0;
      end else if (sync2_q == filt_q) begin
        dcnt_d = '0;
      end else if (dcnt_q >= (bus.cfg_deb_thr_i - DEB_W'(1))) begin
        filt_d = sync2_q;
        dcnt_d = '0;
      end else if (dcnt_q != '1) begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_ACTIVE;
        gcnt_q  <= '0;
        sel_q   <= '0;
        out_q   <= 1'b0;
        oe_q    <= 1'b0;
        done_q  <= 1'b0;
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        filt_q  <= 1'b0;
        dcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        gcnt_q  <= gcnt_d;
        sel_q   <= sel_d;
        out_q   <= out_d;
        oe_q    <= oe_d;
        done_q  <= done_d;
        sync1_q <= bus.pad_in_i[p];
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        dcnt_q  <= dcnt_d;
      end
    end

    always_comb begin
      fin = '0;
      for (int f = 0; f < NUM_FUNC; f++) begin
        if (state_q == ST_ACTIVE && sel_q == SEL_W'(f)) fin[f] = filt_q;
      end
    end

    assign bus.func_in_o[p*NUM_FUNC +: NUM_FUNC] = fin;
    assign bus.pad_out_o[p]     = out_q;
    assign bus.pad_oe_o[p]      = oe_q;
    assign bus.switch_busy_o[p] = (state_q == ST_GUARD);
    assign bus.switch_done_o[p] = done_q;
    assign bus.state_dbg[p]     = (state_q == ST_GUARD);
  end

endmodule

// File: tb/tb_padmux_ctrl.sv
// Self-checking bench for padmux_ctrl: directed switch/park/debounce cases plus
// random traffic against a cycle-level reference model feeding an expected queue.
module tb_padmux_ctrl;
  localparam int NP = 8;
  localparam int NF = 4;
  localparam int SW = 3;
  localparam int GC = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  padmux_if #(.NUM_PADS(NP), .NUM_FUNC(NF), .SEL_W(SW), .DEB_W(DW)) bus ();

  padmux_ctrl #(
    .NUM_PADS(NP), .NUM_FUNC(NF), .SEL_W(SW), .GUARD_CYCLES(GC), .DEB_W(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] exp_q[$];
  logic [NP-1:0] prev_busy;

  // Reference model state
  bit m_guard[NP];
  int m_cnt[NP];
  int m_sel[NP];
  bit m_out[NP], m_oe[NP], m_done[NP];
  bit m_s1[NP], m_s2[NP], m_filt[NP];
  int m_dc[NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_guard[p] = 0; m_cnt[p] = 0; m_sel[p] = 0;
      m_out[p] = 0; m_oe[p] = 0; m_done[p] = 0;
      m_s1[p] = 0; m_s2[p] = 0; m_filt[p] = 0; m_dc[p] = 0;
    end
    prev_busy = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int cs, thr;
    bit nf;
    int nd;
    thr = int'(bus.cfg_deb_thr_i);
    for (int p = 0; p < NP; p++) begin
      cs = int'(bus.cfg_sel_i[p*SW +: SW]);
      m_done[p] = 0;
      if (!m_guard[p]) begin
        if (cs != m_sel[p]) begin
          m_guard[p] = 1; m_cnt[p] = GC - 1; m_out[p] = 0; m_oe[p] = 0;
        end else if (m_sel[p] < NF) begin
          m_out[p] = bus.func_out_i[p*NF + m_sel[p]];
          m_oe[p]  = bus.func_oe_i[p*NF + m_sel[p]];
        end else begin
          m_out[p] = 0; m_oe[p] = 0;
        end
      end else begin
        m_out[p] = 0; m_oe[p] = 0;
        if (m_cnt[p] == 0) begin
          m_sel[p] = cs; m_guard[p] = 0; m_done[p] = 1;
        end else begin
          m_cnt[p]--;
        end
      end
      nf = m_filt[p];
      nd = m_dc[p];
      if (!bus.cfg_deb_en_i[p] || thr == 0) begin
        nf = m_s2[p]; nd = 0;
      end else if (m_s2[p] == m_filt[p]) begin
        nd = 0;
      end else if (m_dc[p] >= thr - 1) begin
        nf = m_s2[p]; nd = 0;
      end else if (m_dc[p] < 255) begin
        nd = m_dc[p] + 1;
      end
      m_filt[p] = nf;
      m_dc[p]   = nd;
      m_s2[p]   = m_s1[p];
      m_s1[p]   = bus.pad_in_i[p];
    end
  endtask

  function automatic logic [63:0] model_outputs();
    logic [31:0] fi;
    logic [7:0] o, e, b, d;
    for (int p = 0; p < NP; p++) begin
      o[p] = m_out[p]; e[p] = m_oe[p]; b[p] = m_guard[p]; d[p] = m_done[p];
      for (int f = 0; f < NF; f++)
        fi[p*NF + f] = m_filt[p] && !m_guard[p] && (m_sel[p] == f);
    end
    return {fi, d, b, e, o};
  endfunction

  function automatic logic [63:0] dut_outputs();
    return {bus.func_in_o, bus.switch_done_o, bus.switch_busy_o, bus.pad_oe_o, bus.pad_out_o};
  endfunction

  // One clock: predict, let the edge happen, compare on the falling edge.
  task automatic cycle();
    logic [63:0] exp_v, got_v;
    model_step();
    exp_q.push_back(model_outputs());
    @(posedge clk);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = dut_outputs();
    check("pad_out", {56'd0, got_v[7:0]},   {56'd0, exp_v[7:0]});
    check("pad_oe",  {56'd0, got_v[15:8]},  {56'd0, exp_v[15:8]});
    check("busy",    {56'd0, got_v[23:16]}, {56'd0, exp_v[23:16]});
    check("done",    {56'd0, got_v[31:24]}, {56'd0, exp_v[31:24]});
    check("func_in", {32'd0, got_v[63:32]}, {32'd0, exp_v[63:32]});
    check("oe_after_busy", {56'd0, bus.pad_oe_o & prev_busy}, 64'd0);
    prev_busy = bus.switch_busy_o;
  endtask

  task automatic set_sel(input int p, input int v);
    bus.cfg_sel_i[p*SW +: SW] = SW'(v);
  endtask

  int busy_n, done_n, done_at, first_drive, hit;
  logic [NP-1:0] other_busy;

  task automatic run_switch(input int pad, input int k_change, input int new_sel);
    busy_n = 0; done_n = 0; done_at = 99; first_drive = 99; other_busy = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == k_change) set_sel(pad, new_sel);
      cycle();
      if (bus.switch_busy_o[pad]) busy_n++;
      if (bus.switch_done_o[pad]) begin done_n++; done_at = k; end
      if (bus.pad_oe_o[pad] && first_drive == 99) first_drive = k;
      other_busy |= bus.switch_busy_o & ~(NP'(1) << pad);
    end
  endtask

  initial begin
    bus.cfg_sel_i     = '0;
    bus.cfg_deb_en_i  = '0;
    bus.cfg_deb_thr_i = '0;
    bus.func_out_i    = '0;
    bus.func_oe_i     = '0;
    bus.pad_in_i      = '0;
    model_reset();

    // Reset state
    #2;
    check("reset_outputs", dut_outputs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic drive, one-cycle latency
    bus.func_oe_i[0]  = 1'b1;
    bus.func_out_i[0] = 1'b1;
    cycle();
    check("t1_oe", {63'd0, bus.pad_oe_o[0]}, 64'd1);
    check("t1_out", {63'd0, bus.pad_out_o[0]}, 64'd1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 check("async_reset", dut_outputs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    cycle();
    check("t2_pre_oe", {63'd0, bus.pad_oe_o[0]}, 64'd1);

    // Switch pad 0 from function 0 to 2
    bus.func_oe_i[2] = 1'b1;
    run_switch(0, 1, 2);
    check("t2_busy_cycles", 64'(busy_n), 64'd4);
    check("t2_done_pulses", 64'(done_n), 64'd1);
    check("t2_done_at", 64'(done_at), 64'd5);
    check("t2_first_drive", 64'(first_drive), 64'd6);
    check("t2_others_busy", {56'd0, other_busy}, 64'd0);

    // 2 -> 3 -> 0 during guard; only function 0 drives
    bus.func_oe_i[3:0] = 4'b0001;
    run_switch(0, 1, 3);
    // mid-guard retarget
    check("t3_mid_state", {63'd0, bus.state_dbg[0]}, 64'd0);
    busy_n = 0; done_n = 0; done_at = 99; first_drive = 99;
    set_sel(0, 2);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) set_sel(0, 3);
      if (k == 3) set_sel(0, 0);
      cycle();
      if (bus.switch_busy_o[0]) busy_n++;
      if (bus.switch_done_o[0]) begin done_n++; done_at = k; end
      if (bus.pad_oe_o[0] && first_drive == 99) first_drive = k;
    end
    check("t3_busy_cycles", 64'(busy_n), 64'd4);
    check("t3_done_pulses", 64'(done_n), 64'd1);
    check("t3_first_drive", 64'(first_drive), 64'd6);

    // Park pad 1 with every function driving
    bus.func_oe_i[7:4]  = 4'hF;
    bus.func_out_i[7:4] = 4'hF;
    bus.pad_in_i[1]     = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    check("t4_pre_fin", {63'd0, bus.func_in_o[4]}, 64'd1);
    check("t4_pre_oe", {63'd0, bus.pad_oe_o[1]}, 64'd1);
    set_sel(1, 7);
    for (int k = 0; k < 8; k++) cycle();
    check("t4_park_oe", {63'd0, bus.pad_oe_o[1]}, 64'd0);
    check("t4_park_out", {63'd0, bus.pad_out_o[1]}, 64'd0);
    check("t4_park_fin", {60'd0, bus.func_in_o[7:4]}, 64'd0);
    check("t4_park_busy", {63'd0, bus.switch_busy_o[1]}, 64'd0);

    // Debounce on pad 2, threshold 5
    bus.cfg_deb_en_i[2] = 1'b1;
    bus.cfg_deb_thr_i   = 8'd5;
    hit = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.pad_in_i[2] = (k <= 3);
      cycle();
      if (bus.func_in_o[8]) hit = 1;
    end
    check("t5_glitch", 64'(hit), 64'd0);
    first_drive = 99;
    bus.pad_in_i[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (bus.func_in_o[8] && first_drive == 99) first_drive = k;
    end
    check("t5_deb_latency", 64'(first_drive), 64'd7);
    bus.cfg_deb_en_i[2] = 1'b0;
    first_drive = 99;
    bus.pad_in_i[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (!bus.func_in_o[8] && first_drive == 99) first_drive = k;
    end
    check("t5_nodeb_latency", 64'(first_drive), 64'd3);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.func_out_i = 32'($urandom);
      bus.func_oe_i  = 32'($urandom);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 7) == 0) set_sel(p, $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) bus.pad_in_i[p] = ~bus.pad_in_i[p];
        if ($urandom_range(0, 31) == 0) bus.cfg_deb_en_i[p] = ~bus.cfg_deb_en_i[p];
      end
      if ($urandom_range(0, 31) == 0) bus.cfg_deb_thr_i = 8'($urandom_range(0, 6));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/padmux_ctrl.md
Name: padmux_ctrl

Overview:
Parametrised pad-multiplexing controller and the successor to the fixed two-function per-pin muxes. It maps NUM_FUNC peripheral functions onto each of NUM_PADS pads. Function switching is break-before-make with a guard interval. Pad inputs are synchronised and can be debounced per pad. It sits between the peripheral subsystem and the chip pad ring; the pad-config register file drives the cfg_* inputs.

Parameters:
NUM_PADS, 8, number of pads; each pad has independent logic.
NUM_FUNC, 4, functions selectable per pad; must be >= 2.
SEL_W, 3, per-pad select width; must satisfy 2**SEL_W > NUM_FUNC so an out-of-range "park" code exists.
GUARD_CYCLES, 4, cycles a pad is held undriven during a switch; must be >= 1.
DEB_W, 8, debounce threshold/counter width.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous reset, active-high.
cfg_sel_i  in  NUM_PADS*SEL_W  requested function per pad; pad p uses bits [p*SEL_W +: SEL_W].
cfg_deb_en_i  in  NUM_PADS  per-pad debounce enable.
cfg_deb_thr_i  in  DEB_W  shared debounce threshold in cycles.
func_out_i  in  NUM_PADS*NUM_FUNC  function output value; index p*NUM_FUNC+f.
func_oe_i  in  NUM_PADS*NUM_FUNC  function output enable, 1 = drive.
func_in_o  out  NUM_PADS*NUM_FUNC  filtered pad input as seen by each function.
pad_in_i  in  NUM_PADS  asynchronous pad input.
pad_out_o  out  NUM_PADS  registered pad output value.
pad_oe_o  out  NUM_PADS  registered pad output enable.
switch_busy_o  out  NUM_PADS  1 while pad is in GUARD.
switch_done_o  out  NUM_PADS  one-cycle pulse when a switch completes.

Behaviour:
- Reset (asynchronous, any time, including mid-GUARD): per pad state=ACTIVE, active_sel=0, guard counter=0, sync/filter/debounce regs=0. All outputs read 0.
- Per-pad FSM, ACTIVE:
  - If cfg_sel != active_sel at an edge: go to GUARD, counter loads GUARD_CYCLES-1, and pad_oe_o/pad_out_o load 0 on that same edge (break immediately).
  - Otherwise pad_out_o <= func_out[p][active_sel] and pad_oe_o <= func_oe[p][active_sel]. Output latency is 1 cycle.
- Per-pad FSM, GUARD:
  - pad_oe_o=0, pad_out_o=0, switch_busy_o=1; counter decrements each cycle.
  - At the edge where counter==0: active_sel <= current cfg_sel, state <= ACTIVE, switch_done_o=1 for the following cycle.
  - cfg_sel changes during GUARD do not restart the count; the value sampled at exit wins, even if it equals the old active_sel.
  - Total undriven time is GUARD_CYCLES+1 cycles before the new function drives.
- Park: an active_sel >= NUM_FUNC is legal. In ACTIVE the pad holds pad_oe_o=0, pad_out_o=0, and all func_in for that pad read 0. Switching into and out of park uses GUARD normally.
- Input path:
  - pad_in_i passes through a 2-flop synchroniser, giving sync.
  - Filter register filt, debounce disabled (or cfg_deb_thr_i==0): filt <= sync, so a pad edge reaches filt in 3 cycles.
  - Debounce enabled, threshold T>=1: counter increments while sync != filt and clears to 0 when sync == filt. When the counter reaches T-1 and sync != filt, filt <= sync and the counter clears. A pulse shorter than T sync cycles is rejected.
  - The counter saturates and never wraps.
  - A threshold change takes effect immediately.
- func_in_o[p][f] = filt[p] when state==ACTIVE and active_sel==f, else 0. It is combinational from registers; all functions of a pad read 0 during GUARD.
- Pads are fully independent; simultaneous switches on several pads do not interact.

Test Plan:
1. Reset, then sel=0 on all pads, func_oe[0][0]=1, func_out[0][0]=1 -> pad_oe_o[0]=1 and pad_out_o[0]=1 one cycle later. Assert rst mid-operation -> all outputs 0 immediately, without waiting for a clock edge.
2. Pad 0 ACTIVE driving, cfg_sel 0->2 at cycle N -> pad_oe_o[0]=0 from N+1; switch_busy_o high for 4 cycles; switch_done_o pulses once; function 2 drives at N+6. Pads 1-7 are unaffected.
3. During GUARD, cfg_sel 2->3->0 -> GUARD is not extended; final active_sel=0; done pulse once.
4. cfg_sel=7 (park) with all func_oe=1 -> pad_oe_o=0 and func_in for that pad all 0 after GUARD.
5. Debounce on, thr=5: 3-cycle glitch on pad_in -> filt unchanged. A stable level change -> filt updates after 2 sync + 5 cycles. Debounce off -> filt updates 3 cycles after the edge.
6. Random sel/func/pad stimulus on 8 pads against a reference model, checking that pad_oe_o never goes high in any cycle where busy was high the previous cycle.
